// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches one 16-bit instruction as two byte reads (low byte first) from a
//   byte-wide memory, addressed straight from the register-file PC. After each
//   byte arrives it pulses pc_inc so the register file advances the PC, then
//   presents the assembled instruction to the control unit.
//
// Ports
//   Clock     in   rising-edge system clock
//   rst       in   asynchronous active-low reset
//   start     in   request one fetch (ignored mid-fetch, not queued)
//   flush     in   abort any fetch, return to IDLE next cycle (beats start)
//   pc_addr   in   current PC from the address register file
//   mem_data  in   memory read data, valid MEM_LAT cycles after mem_rd
//   mem_addr  out  pass-through of pc_addr
//   mem_rd    out  one-cycle read strobe per byte
//   pc_inc    out  one-cycle PC increment request per byte received
//   busy      out  high whenever not IDLE
//   ir_q      out  last completed instruction {hi, lo}
//   ir_valid  out  one-cycle pulse in DONE; ir_q takes the new value on that edge
module instruction_fetch_unit #(
    parameter int MEM_LAT = 1,
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               Clock,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [15:0]        pc_addr,
    input  logic [DATA_W-1:0]  mem_data,
    output logic [15:0]        mem_addr,
    output logic               mem_rd,
    output logic               pc_inc,
    output logic               busy,
    output logic [INSTR_W-1:0] ir_q,
    output logic               ir_valid
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE
    } state_t;

    state_t             state, nextState;
    logic [CNT_W-1:0]   latCnt;
    logic [DATA_W-1:0]  loByte, hiByte;
    logic               latLoad, latDec, capLo, capHi, irLoad;

    // No address state here: the register file owns the PC.
    assign mem_addr = pc_addr;
    assign busy     = (state != IDLE);

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            latCnt <= '0;
            loByte <= '0;
            hiByte <= '0;
            ir_q   <= '0;
        end else begin
            state <= nextState;
            if (latLoad)     latCnt <= LAT_INIT;
            else if (latDec) latCnt <= latCnt - 1'b1;
            if (capLo)  loByte <= mem_data;
            if (capHi)  hiByte <= mem_data;
            // Only a completed fetch reaches here, so ir_q never shows a half instruction.
            if (irLoad) ir_q <= {hiByte, loByte};
        end
    end

    always_comb begin
        nextState = state;
        mem_rd    = 1'b0;
        pc_inc    = 1'b0;
        ir_valid  = 1'b0;
        latLoad   = 1'b0;
        latDec    = 1'b0;
        capLo     = 1'b0;
        capHi     = 1'b0;
        irLoad    = 1'b0;
        if (flush) begin
            // Suppresses every strobe this cycle; a low-byte pc_inc already
            // issued stays issued and the control unit reloads the PC.
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) nextState = ISSUE_LO;
                end
                ISSUE_LO: begin
                    mem_rd    = 1'b1;
                    latLoad   = 1'b1;
                    nextState = WAIT_LO;
                end
                WAIT_LO: begin
                    if (latCnt != '0) begin
                        latDec = 1'b1;
                    end else begin
                        capLo     = 1'b1;
                        pc_inc    = 1'b1;
                        nextState = ISSUE_HI;
                    end
                end
                ISSUE_HI: begin
                    // pc_addr already reflects the increment from WAIT_LO.
                    mem_rd    = 1'b1;
                    latLoad   = 1'b1;
                    nextState = WAIT_HI;
                end
                WAIT_HI: begin
                    if (latCnt != '0) begin
                        latDec = 1'b1;
                    end else begin
                        capHi     = 1'b1;
                        pc_inc    = 1'b1;
                        nextState = DONE;
                    end
                end
                DONE: begin
                    ir_valid  = 1'b1;
                    irLoad    = 1'b1;
                    nextState = start ? ISSUE_LO : IDLE;
                end
                default: nextState = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: two DUTs (MEM_LAT=1 and MEM_LAT=3) share a behavioural
// memory; the bench models the register-file PC (load or increment on pc_inc).
// Inputs change at the falling edge, outputs are sampled 1 ns later.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        startA, flushA, startB;
    logic [15:0] pcA, pcB, addrA, addrB;
    logic [7:0]  dataA, dataB;
    logic        rdA, incA, busyA, validA;
    logic        rdB, incB, busyB, validB;
    logic [15:0] irA, irB;
    logic        pcLd;
    logic [15:0] ldValA, ldValB;
    logic [7:0]  mem [0:65535];

    int total = 0, bad = 0;
    int cycNum, incCntA, rdCntA, validCntA, firstValA, lastValA, incCntB, validCntB, lastValB;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.MEM_LAT(1)) dutA (
        .Clock(clk), .rst(rstN), .start(startA), .flush(flushA), .pc_addr(pcA),
        .mem_data(dataA), .mem_addr(addrA), .mem_rd(rdA), .pc_inc(incA),
        .busy(busyA), .ir_q(irA), .ir_valid(validA));

    instruction_fetch_unit #(.MEM_LAT(3)) dutB (
        .Clock(clk), .rst(rstN), .start(startB), .flush(1'b0), .pc_addr(pcB),
        .mem_data(dataB), .mem_addr(addrB), .mem_rd(rdB), .pc_inc(incB),
        .busy(busyB), .ir_q(irB), .ir_valid(validB));

    // PC only changes between reads, so a combinational read satisfies any latency.
    assign dataA = mem[addrA];
    assign dataB = mem[addrB];

    always @(posedge clk) begin
        if (pcLd) begin
            pcA <= ldValA;
            pcB <= ldValB;
        end else begin
            if (incA) pcA <= pcA + 16'd1;
            if (incB) pcB <= pcB + 16'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic sA, input logic f, input logic sB);
        @(negedge clk);
        startA = sA; flushA = f; startB = sB;
        #1;
        if (incA === 1'b1) incCntA++;
        if (rdA === 1'b1) rdCntA++;
        if (validA === 1'b1) begin
            validCntA++;
            if (validCntA == 1) firstValA = cycNum;
            lastValA = cycNum;
        end
        if (incB === 1'b1) incCntB++;
        if (validB === 1'b1) begin
            validCntB++;
            lastValB = cycNum;
        end
        cycNum++;
    endtask

    task automatic clr();
        cycNum = 0; incCntA = 0; rdCntA = 0; validCntA = 0; firstValA = -1; lastValA = -1;
        incCntB = 0; validCntB = 0; lastValB = -1;
    endtask

    task automatic loadPc(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        startA = 0; flushA = 0; startB = 0;
        pcLd = 1; ldValA = a; ldValB = b;
        @(negedge clk);
        pcLd = 0;
    endtask

    initial begin
        rstN = 0; startA = 0; flushA = 0; startB = 0; pcLd = 0; ldValA = 0; ldValB = 0;
        mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
        mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB; mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
        mem[16'h0200] = 8'h9A; mem[16'h0201] = 8'hBC;
        mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h02;

        // Reset state
        loadPc(16'h0040, 16'hFFFF);
        #1;
        chk("rst busy", {31'd0, busyA}, 0);
        chk("rst mem_rd", {31'd0, rdA}, 0);
        chk("rst pc_inc", {31'd0, incA}, 0);
        chk("rst ir_valid", {31'd0, validA}, 0);
        chk("rst ir_q", {16'd0, irA}, 0);
        @(negedge clk); rstN = 1;

        // 1: single fetch, MEM_LAT=1, valid in cycle 5
        clr();
        cyc(1, 0, 0);
        chk("t1 idle busy", {31'd0, busyA}, 0);
        chk("t1 mem_addr", {16'd0, addrA}, 32'h0040);
        repeat (5) cyc(0, 0, 0);
        chk("t1 valid cycle", lastValA, 5);
        chk("t1 valid count", validCntA, 1);
        chk("t1 pc_inc count", incCntA, 2);
        chk("t1 mem_rd count", rdCntA, 2);
        cyc(0, 0, 0);
        chk("t1 ir_q", {16'd0, irA}, 32'h1234);
        chk("t1 pc", {16'd0, pcA}, 32'h0042);
        chk("t1 busy after", {31'd0, busyA}, 0);

        // 2: start held high -> back-to-back, DONE at cycles 5 and 10
        loadPc(16'h0010, 16'hFFFF);
        clr();
        repeat (7) cyc(1, 0, 0);
        chk("t2 first valid", firstValA, 5);
        chk("t2 ir_q first", {16'd0, irA}, 32'hBBAA);
        repeat (3) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t2 second valid", lastValA, 10);
        chk("t2 valid count", validCntA, 2);
        chk("t2 ir_q second", {16'd0, irA}, 32'hDDCC);
        chk("t2 pc_inc count", incCntA, 4);
        chk("t2 pc", {16'd0, pcA}, 32'h0014);
        chk("t2 idle", {31'd0, busyA}, 0);

        // 3: flush in WAIT_HI, then flush+start together in IDLE
        loadPc(16'h0100, 16'hFFFF);
        clr();
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        chk("t3 in wait_hi", {31'd0, busyA}, 1);
        cyc(0, 1, 0);
        chk("t3 flush pc_inc", {31'd0, incA}, 0);
        chk("t3 flush valid", {31'd0, validA}, 0);
        cyc(1, 1, 0);
        chk("t3 idle after flush", {31'd0, busyA}, 0);
        cyc(0, 0, 0);
        chk("t3 flush beats start", {31'd0, busyA}, 0);
        chk("t3 pc_inc count", incCntA, 1);
        chk("t3 valid count", validCntA, 0);
        chk("t3 ir_q kept", {16'd0, irA}, 32'hDDCC);
        chk("t3 pc", {16'd0, pcA}, 32'h0101);

        // 4: MEM_LAT=3 with PC wrap, valid in cycle 9
        loadPc(pcA, 16'hFFFF);
        clr();
        cyc(0, 0, 1);
        repeat (9) cyc(0, 0, 0);
        chk("t4 valid cycle", lastValB, 9);
        chk("t4 valid count", validCntB, 1);
        cyc(0, 0, 0);
        chk("t4 ir_q", {16'd0, irB}, 32'h5678);
        chk("t4 pc wrap", {16'd0, pcB}, 32'h0001);
        chk("t4 pc_inc count", incCntB, 2);

        // 5: reset during WAIT_LO, then a normal fetch
        loadPc(16'h0200, 16'hFFFF);
        clr();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        @(negedge clk);
        rstN = 0;
        #1;
        chk("t5 rst busy", {31'd0, busyA}, 0);
        chk("t5 rst mem_rd", {31'd0, rdA}, 0);
        chk("t5 rst pc_inc", {31'd0, incA}, 0);
        chk("t5 rst ir_valid", {31'd0, validA}, 0);
        chk("t5 rst ir_q", {16'd0, irA}, 0);
        @(negedge clk); rstN = 1;
        chk("t5 pc unchanged", {16'd0, pcA}, 32'h0200);
        clr();
        cyc(1, 0, 0);
        repeat (6) cyc(0, 0, 0);
        chk("t5 valid cycle", lastValA, 5);
        chk("t5 ir_q", {16'd0, irA}, 32'hBC9A);
        chk("t5 pc", {16'd0, pcA}, 32'h0202);

        // 6: start pulsed in ISSUE_HI is not queued
        loadPc(16'h0300, 16'hFFFF);
        clr();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
        chk("t6 valid count", validCntA, 1);
        chk("t6 valid cycle", lastValA, 5);
        chk("t6 mem_rd count", rdCntA, 2);
        chk("t6 idle", {31'd0, busyA}, 0);
        chk("t6 ir_q", {16'd0, irA}, 32'h0201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
